vx_scalar_operand_collector: RTL

//  Upstream producer of the scalar operand bundle (VX_operands_scalar_if.data_t layout) consumed by

---
 rtl/vx_scalar_operand_collector.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/vx_scalar_operand_collector.sv
// Scalar operand collector: latches one issued instruction, reads its nonzero source registers
// serially through one GPR read port, and presents the operand bundle with a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for an instruction (in_ready=1)
// READ  | one GPR read request per cycle for each pending register
// DRAIN | capture of the last requested operand
// OUT   | bundle valid, held until out_ready
//
// out_data layout (MSB first): {uuid, wis, tmask, PC, ex_type, op_type, op_mod, wb, use_PC,
// use_imm, imm, rd, rs1_data[THREAD_CNT], rs2_data[THREAD_CNT], rs3_data[THREAD_CNT], is_branch},
// where lane 0 of each rsN_data is the least significant XLEN bits.
module vx_scalar_operand_collector #(
    parameter int THREAD_CNT  = 4,
    parameter int WARP_CNT    = 8,
    parameter int ISSUE_CNT   = (WARP_CNT < 4) ? WARP_CNT : 4,
    parameter int ISSUE_WIS_W = ((WARP_CNT / ISSUE_CNT) > 1) ? $clog2(WARP_CNT / ISSUE_CNT) : 1,
    parameter int NR_BITS     = 5,
    parameter int XLEN        = 32,
    parameter int UUID_W      = 44,
    parameter int PC_W        = 32,
    parameter int EX_W        = 3,
    parameter int OP_W        = 4,
    parameter int MOD_W       = 3,
    parameter int IN_W        = UUID_W + ISSUE_WIS_W + THREAD_CNT + PC_W + EX_W + OP_W + MOD_W
                                + 3 + XLEN + 4 * NR_BITS + 1,
    parameter int DATA_W      = UUID_W + ISSUE_WIS_W + THREAD_CNT + PC_W + EX_W + OP_W + MOD_W
                                + 3 + XLEN + NR_BITS + 3 * THREAD_CNT * XLEN + 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IN_W-1:0]        in_data,
    output logic                   gpr_rd_req,
    output logic [ISSUE_WIS_W-1:0] gpr_rd_wis,
    output logic [NR_BITS-1:0]     gpr_rd_addr,
    input  logic [XLEN-1:0]        gpr_rd_data,
    input  logic                   wb_valid,
    input  logic [ISSUE_WIS_W-1:0] wb_wis,
    input  logic [NR_BITS-1:0]     wb_rd,
    input  logic [XLEN-1:0]        wb_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data
);

    typedef struct packed {
        logic [UUID_W-1:0]      uuid;
        logic [ISSUE_WIS_W-1:0] wis;
        logic [THREAD_CNT-1:0]  tmask;
        logic [PC_W-1:0]        pc;
        logic [EX_W-1:0]        ex_type;
        logic [OP_W-1:0]        op_type;
        logic [MOD_W-1:0]       op_mod;
        logic                   wb;
        logic                   use_pc;
        logic                   use_imm;
        logic [XLEN-1:0]        imm;
        logic [NR_BITS-1:0]     rd;
        logic [NR_BITS-1:0]     rs1;
        logic [NR_BITS-1:0]     rs2;
        logic [NR_BITS-1:0]     rs3;
        logic                   is_branch;
    } in_t;

    typedef struct packed {
        logic [UUID_W-1:0]                  uuid;
        logic [ISSUE_WIS_W-1:0]             wis;
        logic [THREAD_CNT-1:0]              tmask;
        logic [PC_W-1:0]                    pc;
        logic [EX_W-1:0]                    ex_type;
        logic [OP_W-1:0]                    op_type;
        logic [MOD_W-1:0]                   op_mod;
        logic                               wb;
        logic                               use_pc;
        logic                               use_imm;
        logic [XLEN-1:0]                    imm;
        logic [NR_BITS-1:0]                 rd;
        logic [THREAD_CNT-1:0][XLEN-1:0]    rs1_data;
        logic [THREAD_CNT-1:0][XLEN-1:0]    rs2_data;
        logic [THREAD_CNT-1:0][XLEN-1:0]    rs3_data;
        logic                               is_branch;
    } out_t;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_OUT} state_e;

    in_t                           in_s;
    logic [2:0][NR_BITS-1:0]       rs_in;

    state_e                        state_q, state_d;
    out_t                          out_q, out_d;
    logic                          out_valid_q, out_valid_d;
    logic [2:0][NR_BITS-1:0]       pend_reg_q, pend_reg_d;
    logic [2:0][1:0]               pend_slot_q, pend_slot_d;
    logic [1:0]                    pend_cnt_q, pend_cnt_d;
    logic [1:0]                    rd_idx_q, rd_idx_d;
    logic                          cap_valid_q, cap_valid_d;
    logic [1:0]                    cap_slot_q, cap_slot_d;
    logic [NR_BITS-1:0]            cap_reg_q, cap_reg_d;

    logic [2:0][NR_BITS-1:0]       new_reg;
    logic [2:0][1:0]               new_slot;
    logic [1:0]                    new_cnt;
    logic                          cap_bypass;
    logic [XLEN-1:0]               cap_val;

    assign in_s  = in_data;
    assign rs_in = {in_s.rs3, in_s.rs2, in_s.rs1};

    // Compacted list of nonzero source registers in rs1, rs2, rs3 order, with their operand slot.
    always_comb begin
        new_reg  = '0;
        new_slot = '0;
        new_cnt  = '0;
        for (int j = 0; j < 3; j++) begin
            if (rs_in[j] != '0) begin
                new_reg[new_cnt]  = rs_in[j];
                new_slot[new_cnt] = 2'(j);
                new_cnt           = new_cnt + 2'd1;
            end
        end
    end

    // A writeback landing in the same cycle as the read data is newer than the register file.
    assign cap_bypass = wb_valid && (wb_wis == out_q.wis) && (wb_rd == cap_reg_q) && (cap_reg_q != '0);
    assign cap_val    = cap_bypass ? wb_data : gpr_rd_data;

    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        pend_reg_d  = pend_reg_q;
        pend_slot_d = pend_slot_q;
        pend_cnt_d  = pend_cnt_q;
        rd_idx_d    = rd_idx_q;
        cap_valid_d = 1'b0;
        cap_slot_d  = cap_slot_q;
        cap_reg_d   = cap_reg_q;

        if (cap_valid_q) begin
            for (int i = 0; i < THREAD_CNT; i++) begin
                case (cap_slot_q)
                    2'd0:    out_d.rs1_data[i] = cap_val;
                    2'd1:    out_d.rs2_data[i] = cap_val;
                    default: out_d.rs3_data[i] = cap_val;
                endcase
            end
        end

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    out_d           = '0;
                    out_d.uuid      = in_s.uuid;
                    out_d.wis       = in_s.wis;
                    out_d.tmask     = in_s.tmask;
                    out_d.pc        = in_s.pc;
                    out_d.ex_type   = in_s.ex_type;
                    out_d.op_type   = in_s.op_type;
                    out_d.op_mod    = in_s.op_mod;
                    out_d.wb        = in_s.wb;
                    out_d.use_pc    = in_s.use_pc;
                    out_d.use_imm   = in_s.use_imm;
                    out_d.imm       = in_s.imm;
                    out_d.rd        = in_s.rd;
                    out_d.is_branch = in_s.is_branch;
                    pend_reg_d      = new_reg;
                    pend_slot_d     = new_slot;
                    pend_cnt_d      = new_cnt;
                    rd_idx_d        = '0;
                    if (new_cnt == '0) begin
                        state_d     = S_OUT;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d     = S_READ;
                    end
                end
            end
            S_READ: begin
                cap_valid_d = 1'b1;
                cap_slot_d  = pend_slot_q[rd_idx_q];
                cap_reg_d   = pend_reg_q[rd_idx_q];
                rd_idx_d    = rd_idx_q + 2'd1;
                if (rd_idx_q == pend_cnt_q - 2'd1) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_d     = S_OUT;
                out_valid_d = 1'b1;
            end
            default: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            pend_reg_q  <= '0;
            pend_slot_q <= '0;
            pend_cnt_q  <= '0;
            rd_idx_q    <= '0;
            cap_valid_q <= 1'b0;
            cap_slot_q  <= '0;
            cap_reg_q   <= '0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            pend_reg_q  <= pend_reg_d;
            pend_slot_q <= pend_slot_d;
            pend_cnt_q  <= pend_cnt_d;
            rd_idx_q    <= rd_idx_d;
            cap_valid_q <= cap_valid_d;
            cap_slot_q  <= cap_slot_d;
            cap_reg_q   <= cap_reg_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = out_valid_q;
    assign out_data    = out_q;
    assign gpr_rd_req  = (state_q == S_READ);
    assign gpr_rd_wis  = out_q.wis;
    assign gpr_rd_addr = pend_reg_q[rd_idx_q];

endmodule
